mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 mem_read_flag  input  1  the current MEM-stage instruction is a load.
REQ-004 mem_write_flag  input  1  the current MEM-stage instruction is a store.
REQ-005 mem_sign_ext_flag  input  1  sign-extend load data (LB/LH/LW); 0 means zero-extend.
REQ-006 mem_sel  input  4  access width: 0001 byte, 0011 half, 1111 word; other codes mean no access.
REQ-007 mem_write_data  input  32  store data, right-aligned in the low bits.
REQ-008 mem_addr  input  32  effective byte address.
REQ-009 flush  input  1  discard the in-flight access result.
REQ-010 ram_en  output  1  bus request, held until ram_ready.
REQ-011 ram_write_en  output  4  per-byte write strobes; 0000 means read.
REQ-012 ram_addr  output  32  word-aligned bus address.
REQ-013 ram_write_data  output  32  lane-replicated store data.
REQ-014 ram_read_data  input  32  bus read word, valid when ram_ready=1.
REQ-015 ram_ready  input  1  bus completion, one cycle per request.
REQ-016 read_data  output  32  aligned and extended load result.
REQ-017 result_valid  output  1  single-cycle pulse: the access has completed.
REQ-018 stall_request  output  1  hold the upstream pipeline.
REQ-019 addr_error_load / addr_error_store  output  1 each  misalignment exception pulses.

Function
REQ-020 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-021 An access is valid when (mem_read_flag|mem_write_flag) is 1 and mem_sel is legal.
  - If both flags are 1, the access SHALL be treated as a write.
REQ-022 Alignment SHALL be checked in IDLE.
  - mem_sel=0011 requires mem_addr[0]=0.
  - mem_sel=1111 requires mem_addr[1:0]=00.
REQ-023 A misaligned valid access SHALL:
  - pulse addr_error_load or addr_error_store for one cycle, combinationally in IDLE;
  - issue no bus request;
  - not assert stall_request;
  - stay in IDLE.
REQ-024 An aligned valid access in IDLE SHALL be latched and SHALL move the FSM to REQ.
  - Latched fields: addr, sel, write data, sign flag, direction.
  - stall_request=1 combinationally in that same cycle.
REQ-025 In REQ the block SHALL drive the bus from the latched values:
  - ram_en=1;
  - ram_addr={addr[31:2],2'b00};
  - ram_write_en=(sel<<addr[1:0]) for writes, 0000 for reads;
  - stall_request=1.
REQ-026 ram_write_data SHALL be {4{data[7:0]}} for byte, {2{data[15:0]}} for half, and data for word.
REQ-027 REQ SHALL persist while ram_ready=0, with all bus outputs stable.
REQ-028 On ram_ready=1 in REQ:
  - read_data SHALL register (ram_read_data>>(8*addr[1:0])), masked to 8/16/32 bits and sign- or zero-extended;
  - writes SHALL register read_data=0;
  - the FSM SHALL move to DONE.
REQ-029 In DONE: result_valid=1 and stall_request=0 for exactly one cycle, then IDLE.
  - read_data SHALL hold its value until the next completion.
REQ-030 Minimum latency, accept to result_valid, SHALL be 2 cycles (ram_ready in the first REQ cycle).
REQ-031 flush in REQ SHALL NOT abort the bus request.
  - On ram_ready the FSM SHALL go to IDLE, with no result_valid and read_data unchanged.
  - flush in IDLE or DONE SHALL suppress acceptance and error pulses in that cycle.
REQ-032 In IDLE with no access: ram_en=0, ram_write_en=0000, stall_request=0.

Reset
REQ-033 On rst=1 the block SHALL asynchronously:
  - enter IDLE;
  - clear all latched registers and read_data;
  - drive every output to 0.
REQ-034 rst asserted while in REQ SHALL drop ram_en immediately; the pending bus ready SHALL be ignored.

Verification
REQ-035 LB, addr=0x1003, ram_read_data=0x80AABBCC, ready in the first REQ cycle -> ram_addr=0x1000, ram_write_en=0000, read_data=0xFFFFFF80, result_valid 2 cycles after accept.
REQ-036 SH, addr=0x2002, data=0x1234ABCD, ready after 3 wait cycles -> ram_write_en=1100, ram_write_data=0xABCDABCD held 4 cycles, stall_request=1 for 5 cycles.
REQ-037 LHU, addr=0x3002, read word 0x8001FFFF -> read_data=0x00008001; LH of the same word -> 0xFFFF8001.
REQ-038 LW, addr=0x4002 -> addr_error_load pulses 1 cycle, ram_en stays 0, stall_request=0; SH, addr=0x4001 -> addr_error_store pulses.
REQ-039 LW accepted, flush in REQ, ready 2 cycles later -> no result_valid, read_data retains its prior value, FSM returns to IDLE.
REQ-040 rst pulsed mid-REQ -> all outputs 0 in the same cycle; a later ram_ready produces no result_valid.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller.
// Latches one load/store, runs it over a single-request RAM bus, and returns
// the aligned, extended load data. Misaligned accesses raise an exception
// pulse and never reach the bus.
module mem_access_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_read_flag,
  input  logic        i_mem_write_flag,
  input  logic        i_mem_sign_ext_flag,
  input  logic [3:0]  i_mem_sel,
  input  logic [31:0] i_mem_write_data,
  input  logic [31:0] i_mem_addr,
  input  logic        i_flush,
  output logic        o_ram_en,
  output logic [3:0]  o_ram_write_en,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_write_data,
  input  logic [31:0] i_ram_read_data,
  input  logic        i_ram_ready,
  output logic [31:0] o_read_data,
  output logic        o_result_valid,
  output logic        o_stall_request,
  output logic        o_addr_error_load,
  output logic        o_addr_error_store
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic        r_sign;
  logic        r_write;
  logic        r_flushed;
  logic [31:0] r_read_data;

  // Natural alignment: halves on even bytes, words on multiples of four.
  function automatic logic f_aligned(input logic [3:0] sel, input logic [1:0] off);
    case (sel)
      4'b0011: f_aligned = (off[0] == 1'b0);
      4'b1111: f_aligned = (off == 2'b00);
      default: f_aligned = 1'b1;
    endcase
  endfunction

  // Copy the store data into every byte lane so the strobes pick the right one.
  function automatic logic [31:0] f_replicate(input logic [3:0] sel, input logic [31:0] data);
    case (sel)
      4'b0001: f_replicate = {4{data[7:0]}};
      4'b0011: f_replicate = {2{data[15:0]}};
      default: f_replicate = data;
    endcase
  endfunction

  // Shift the addressed lane down, then mask and extend to 32 bits.
  function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] off,
                                           input logic [3:0] sel, input logic sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (sel)
      4'b0001: f_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      4'b0011: f_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: f_extend = sh;
    endcase
  endfunction

  logic w_sel_legal;
  logic w_access;
  logic w_aligned;
  logic w_accept;
  logic w_misalign;
  logic w_in_req;

  assign w_sel_legal = (i_mem_sel == 4'b0001) || (i_mem_sel == 4'b0011) || (i_mem_sel == 4'b1111);
  // Only IDLE looks at the pipeline; flush and reset mask the request outright.
  assign w_access    = (i_mem_read_flag | i_mem_write_flag) & w_sel_legal & ~i_flush & ~i_rst
                       & (r_state == ST_IDLE);
  assign w_aligned   = f_aligned(i_mem_sel, i_mem_addr[1:0]);
  assign w_accept    = w_access & w_aligned;
  assign w_misalign  = w_access & ~w_aligned;
  assign w_in_req    = (r_state == ST_REQ);

  // A store wins when both direction flags are set.
  assign o_addr_error_store = w_misalign & i_mem_write_flag;
  assign o_addr_error_load  = w_misalign & ~i_mem_write_flag;
  assign o_stall_request    = ~i_rst & (w_accept | w_in_req);

  // Bus side is driven purely from latched state, so it is stable across wait cycles.
  assign o_ram_en         = w_in_req;
  assign o_ram_addr       = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign o_ram_write_en   = (w_in_req & r_write) ? (r_sel << r_addr[1:0]) : 4'b0000;
  assign o_ram_write_data = w_in_req ? r_wdata : 32'd0;
  assign o_result_valid   = (r_state == ST_DONE);
  assign o_read_data      = r_read_data;

  // Access FSM: latch in IDLE, wait for ready in REQ, one-cycle DONE pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= 32'd0;
      r_sel       <= 4'd0;
      r_wdata     <= 32'd0;
      r_sign      <= 1'b0;
      r_write     <= 1'b0;
      r_flushed   <= 1'b0;
      r_read_data <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr    <= i_mem_addr;
            r_sel     <= i_mem_sel;
            r_wdata   <= f_replicate(i_mem_sel, i_mem_write_data);
            r_sign    <= i_mem_sign_ext_flag;
            r_write   <= i_mem_write_flag;
            r_flushed <= 1'b0;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A flush cannot cancel the bus transfer, only its result.
          if (i_flush) begin
            r_flushed <= 1'b1;
          end
          if (i_ram_ready) begin
            if (r_flushed | i_flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_read_data <= r_write ? 32'd0
                                     : f_extend(i_ram_read_data, r_addr[1:0], r_sel, r_sign);
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
